calc_ctrl: RTL and testbench

Sequencing controller for the calculator datapath. It debounces the execute button and samples the encoded ALU operation from the button encoder. It then issues one accumulate step to the ALU (accumulator as operand A, switches as operand B) and writes the result back into a 16-bit accumulator shown on the LEDs. It sits between the board I/O and the ALU, and is the only block that drives ALU operands and opcode.

---
 rtl/calc_pkg.sv | 13 +
 rtl/calc_ctrl_btn_debounce.sv | 50 +++++
 rtl/calc_ctrl.sv | 108 ++++++++++
 tb/tb_calc_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants and state encoding for the calculator sequencing controller.
package calc_pkg;
  localparam int OP_W       = 4;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_SW_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;
endpackage

// File: rtl/calc_ctrl_btn_debounce.sv
// Synchronizes the raw execute button and emits a single-cycle pulse once a
// press has been stable; re-arms only after an equally stable release.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt counts consecutive samples disagreeing with the accepted level
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;
endmodule

// File: rtl/calc_ctrl.sv
// Calculator sequencer: latches opcode/operand on a debounced press, waits for
// the ALU, then writes the truncated result and overflow into the accumulator.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int DATA_W          = DEF_DATA_W,
  parameter int SW_W            = DEF_SW_W,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ALU_LAT         = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btnc,
  input  logic              clr,
  input  logic [OP_W-1:0]   op_sel,
  input  logic [SW_W-1:0]   sw,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_ovf,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SW_W-1:0]   accum,
  output logic              ovf_flag,
  output logic              busy
);
  localparam int WC_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  logic press;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [SW_W-1:0]   accum_q, accum_d;
  logic              ovf_q, ovf_d;
  logic [WC_W-1:0]   wait_q, wait_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btnc),
    .press  (press)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    b_d     = b_q;
    accum_d = accum_q;
    ovf_d   = ovf_q;
    wait_d  = wait_q;
    if (clr) begin
      state_d = ST_IDLE;
      accum_d = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press) begin
            state_d = ST_ISSUE;
            op_d    = op_sel;
            b_d     = {{(DATA_W-SW_W){sw[SW_W-1]}}, sw};
          end
        end
        ST_ISSUE: begin
          wait_d  = '0;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_q == WC_W'(ALU_LAT - 1)) state_d = ST_WRITE;
          else wait_d = wait_q + 1'b1;
        end
        ST_WRITE: begin
          // result must fit the accumulator as a signed value
          accum_d = alu_result[SW_W-1:0];
          ovf_d   = alu_ovf |
                    (alu_result[DATA_W-1:SW_W] != {(DATA_W-SW_W){alu_result[SW_W-1]}});
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      b_q     <= '0;
      accum_q <= '0;
      ovf_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      b_q     <= b_d;
      accum_q <= accum_d;
      ovf_q   <= ovf_d;
      wait_q  <= wait_d;
    end
  end

  assign alu_op   = op_q;
  assign alu_b    = b_q;
  assign alu_a    = {{(DATA_W-SW_W){accum_q[SW_W-1]}}, accum_q};
  assign accum    = accum_q;
  assign ovf_flag = ovf_q;
  assign busy     = (state_q != ST_IDLE);
endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl with a behavioural add/subtract ALU.
module tb_calc_ctrl;
  localparam int DATA_W  = 32;
  localparam int SW_W    = 16;
  localparam int DEB     = 4;
  localparam int ALU_LAT = 24;

  logic              clk = 1'b0;
  logic              rst_n, btnc, clr, alu_ovf_force;
  logic [3:0]        op_sel;
  logic [SW_W-1:0]   sw;
  logic [DATA_W-1:0] alu_result;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic [SW_W-1:0]   accum;
  logic              ovf_flag, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int op_starts = 0;
  logic busy_prev = 1'b0;

  calc_ctrl #(.DATA_W(DATA_W), .SW_W(SW_W), .DEBOUNCE_CYCLES(DEB), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .btnc(btnc), .clr(clr), .op_sel(op_sel), .sw(sw),
    .alu_result(alu_result), .alu_ovf(alu_ovf_force), .alu_op(alu_op), .alu_a(alu_a),
    .alu_b(alu_b), .accum(accum), .ovf_flag(ovf_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result = '0;
    if (alu_op == 4'h2) alu_result = alu_a + alu_b;
    else if (alu_op == 4'h3) alu_result = alu_a - alu_b;
  end

  always @(negedge clk) begin
    busy_prev <= busy;
    if (busy && !busy_prev) op_starts <= op_starts + 1;
  end

  task automatic run_op(input logic [3:0] op, input logic [SW_W-1:0] v,
                        output int bcnt, output bit got);
    op_sel = op; sw = v; btnc = 1'b1; got = 1'b0; bcnt = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (busy) got = 1'b1;
    end
    if (got) while (busy && bcnt < 200) begin bcnt++; @(negedge clk); end
    btnc = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic clr_pulse();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic test_reset();
    bit got;
    n_checks += 5;
    if (accum !== 16'h0)    begin n_fail++; $display("FAIL reset_accum got %h exp 0000", accum); end
    if (ovf_flag !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf got %b exp 0", ovf_flag); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    if (alu_op !== 4'h0)    begin n_fail++; $display("FAIL reset_op got %h exp 0", alu_op); end
    if (alu_b !== 32'h0)    begin n_fail++; $display("FAIL reset_b got %h exp 0", alu_b); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    op_sel = 4'h2; sw = 16'h0009; btnc = 1'b1; got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin @(negedge clk); if (busy) got = 1'b1; end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL midwait_start got busy=0 exp busy=1"); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks += 5;
    if (busy !== 1'b0)     begin n_fail++; $display("FAIL midwait_busy got %b exp 0", busy); end
    if (accum !== 16'h0)   begin n_fail++; $display("FAIL midwait_accum got %h exp 0000", accum); end
    if (alu_op !== 4'h0)   begin n_fail++; $display("FAIL midwait_op got %h exp 0", alu_op); end
    if (alu_b !== 32'h0)   begin n_fail++; $display("FAIL midwait_b got %h exp 0", alu_b); end
    if (ovf_flag !== 1'b0) begin n_fail++; $display("FAIL midwait_ovf got %b exp 0", ovf_flag); end
    btnc = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (ALU_LAT + 10) @(negedge clk);
    n_checks += 2;
    if (accum !== 16'h0) begin n_fail++; $display("FAIL postreset_accum got %h exp 0000", accum); end
    if (busy !== 1'b0)   begin n_fail++; $display("FAIL postreset_busy got %b exp 0", busy); end
  endtask

  task automatic test_basic();
    int bc; bit got;
    run_op(4'h2, 16'h0005, bc, got);
    n_checks += 5;
    if (!got)                  begin n_fail++; $display("FAIL basic_start got no busy exp busy"); end
    if (alu_b !== 32'h5)       begin n_fail++; $display("FAIL basic_b got %h exp 00000005", alu_b); end
    if (alu_op !== 4'h2)       begin n_fail++; $display("FAIL basic_op got %h exp 2", alu_op); end
    if (bc != 2 + ALU_LAT)     begin n_fail++; $display("FAIL basic_busy_len got %0d exp %0d", bc, 2 + ALU_LAT); end
    if (accum !== 16'h0005)    begin n_fail++; $display("FAIL basic_accum got %h exp 0005", accum); end
  endtask

  task automatic test_sign_ovf();
    int bc; bit got;
    clr_pulse();
    run_op(4'h2, 16'h7FFF, bc, got);
    n_checks += 2;
    if (accum !== 16'h7FFF)     begin n_fail++; $display("FAIL sext_accum got %h exp 7fff", accum); end
    if (alu_a !== 32'h00007FFF) begin n_fail++; $display("FAIL sext_a_pos got %h exp 00007fff", alu_a); end
    run_op(4'h2, 16'h0001, bc, got);
    n_checks += 3;
    if (accum !== 16'h8000)     begin n_fail++; $display("FAIL ovf_accum got %h exp 8000", accum); end
    if (ovf_flag !== 1'b1)      begin n_fail++; $display("FAIL ovf_set got %b exp 1", ovf_flag); end
    if (alu_a !== 32'hFFFF8000) begin n_fail++; $display("FAIL sext_a_neg got %h exp ffff8000", alu_a); end
    run_op(4'h3, 16'hFFFF, bc, got);
    n_checks += 3;
    if (alu_b !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL sext_b got %h exp ffffffff", alu_b); end
    if (accum !== 16'h8001)     begin n_fail++; $display("FAIL sub_accum got %h exp 8001", accum); end
    if (ovf_flag !== 1'b0)      begin n_fail++; $display("FAIL ovf_clear got %b exp 0", ovf_flag); end
    alu_ovf_force = 1'b1;
    run_op(4'h2, 16'h0000, bc, got);
    alu_ovf_force = 1'b0;
    n_checks += 2;
    if (ovf_flag !== 1'b1)      begin n_fail++; $display("FAIL aluovf_flag got %b exp 1", ovf_flag); end
    if (accum !== 16'h8001)     begin n_fail++; $display("FAIL aluovf_accum got %h exp 8001", accum); end
  endtask

  task automatic test_bounce();
    int start;
    clr_pulse();
    op_sel = 4'h2; sw = 16'h0003;
    start = op_starts;
    for (int i = 0; i < 5; i++) begin
      btnc = 1'b1; repeat (2) @(negedge clk);
      btnc = 1'b0; repeat (2) @(negedge clk);
    end
    btnc = 1'b1;
    repeat (ALU_LAT + 60) @(negedge clk);
    n_checks += 2;
    if (op_starts - start != 1) begin n_fail++; $display("FAIL bounce_ops got %0d exp 1", op_starts - start); end
    if (accum !== 16'h0003)     begin n_fail++; $display("FAIL bounce_accum got %h exp 0003", accum); end
    btnc = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_busy_drop();
    int start; bit got;
    start = op_starts;
    op_sel = 4'h2; sw = 16'h0001; btnc = 1'b1; got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin @(negedge clk); if (busy) got = 1'b1; end
    btnc = 1'b0; op_sel = 4'h3; sw = 16'h0100;
    repeat (8) @(negedge clk);
    btnc = 1'b1;
    repeat (9) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL drop_still_busy got %b exp 1", busy); end
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    repeat (40) @(negedge clk);
    btnc = 1'b0;
    repeat (10) @(negedge clk);
    n_checks += 4;
    if (op_starts - start != 1) begin n_fail++; $display("FAIL drop_ops got %0d exp 1", op_starts - start); end
    if (accum !== 16'h0004)     begin n_fail++; $display("FAIL drop_accum got %h exp 0004", accum); end
    if (alu_op !== 4'h2)        begin n_fail++; $display("FAIL drop_op got %h exp 2", alu_op); end
    if (alu_b !== 32'h1)        begin n_fail++; $display("FAIL drop_b got %h exp 00000001", alu_b); end
  endtask

  task automatic test_clr();
    int start; bit got;
    op_sel = 4'h2; sw = 16'h000A; btnc = 1'b1; got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin @(negedge clk); if (busy) got = 1'b1; end
    repeat (ALU_LAT + 1) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL clrwr_in_write got busy=%b exp 1", busy); end
    alu_ovf_force = 1'b1; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; alu_ovf_force = 1'b0;
    n_checks += 3;
    if (accum !== 16'h0)   begin n_fail++; $display("FAIL clrwr_accum got %h exp 0000", accum); end
    if (ovf_flag !== 1'b0) begin n_fail++; $display("FAIL clrwr_ovf got %b exp 0", ovf_flag); end
    if (busy !== 1'b0)     begin n_fail++; $display("FAIL clrwr_busy got %b exp 0", busy); end
    btnc = 1'b0;
    repeat (10) @(negedge clk);
    start = op_starts;
    clr = 1'b1; btnc = 1'b1;
    repeat (15) @(negedge clk);
    clr = 1'b0;
    repeat (10) @(negedge clk);
    n_checks += 2;
    if (op_starts - start != 0) begin n_fail++; $display("FAIL clrpress_ops got %0d exp 0", op_starts - start); end
    if (accum !== 16'h0)        begin n_fail++; $display("FAIL clrpress_accum got %h exp 0000", accum); end
    btnc = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; btnc = 1'b0; clr = 1'b0; alu_ovf_force = 1'b0;
    op_sel = 4'h0; sw = '0;
    #1;
    test_reset();
    test_basic();
    test_sign_ovf();
    test_bounce();
    test_busy_drop();
    test_clr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
